// File: rtl/dmem_ctrl_if.sv
// Memory-side bus between dmem_ctrl and the data memory.
// The master (dmem_ctrl) issues a registered request with latched address/data;
// the slave (memory) answers with a one-cycle ack and, for reads, the data.
interface dmem_ctrl_if #(
   parameter int N = 16
);
   logic         bus_req;
   logic         bus_we;
   logic [N-1:0] bus_addr;
   logic [N-1:0] bus_wdata;
   logic [N-1:0] bus_rdata;
   logic         bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_rdata, bus_ack
   );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns a datapath load/store request into one bus
// transfer and stalls the datapath until the transfer completes.
// Optional feature: define DMEM_CTRL_TIMEOUT_EN to abort a transfer after
// TIMEOUT BUSY cycles without bus_ack and raise a sticky err flag.
module dmem_ctrl #(
   parameter int N       = 16,
   parameter int TIMEOUT = 15
) (
   input  logic         clk,
   input  logic         reset,     // synchronous, active-low
   input  logic         memread,
   input  logic         memwrite,
   input  logic [N-1:0] addr,
   input  logic [N-1:0] wdata,
   output logic [N-1:0] rdata,
   output logic         stall,
   output logic         err,
   dmem_ctrl_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;

`ifdef DMEM_CTRL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt;
`else
   // Parameter kept for interface compatibility; no counter exists here.
   localparam int unused_timeout = TIMEOUT;
   assign err = 1'b0;
`endif

   // The datapath must hold while a request is being accepted or in flight;
   // DONE releases it for exactly one cycle.
   assign stall = (state == BUSY) || ((state == IDLE) && (memread || memwrite));

   // Controller FSM with registered bus outputs and read-data capture.
   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge, so it lives inside the
      // clocked branch rather than in the sensitivity list.
      if (!reset) begin
         state         <= IDLE;
         bus.bus_req   <= 1'b0;
         bus.bus_we    <= 1'b0;
         bus.bus_addr  <= '0;
         bus.bus_wdata <= '0;
         rdata         <= '0;
`ifdef DMEM_CTRL_TIMEOUT_EN
         err           <= 1'b0;
         cnt           <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register sees the
         // pre-edge values of the others, independent of statement order.
         case (state)
            IDLE: begin
               if (memread || memwrite) begin
                  // A simultaneous read+write becomes a write.
                  bus.bus_addr  <= addr;
                  bus.bus_wdata <= wdata;
                  bus.bus_we    <= memwrite;
                  bus.bus_req   <= 1'b1;
`ifdef DMEM_CTRL_TIMEOUT_EN
                  cnt           <= '0;
`endif
                  state         <= BUSY;
               end
            end

            BUSY: begin
               if (bus.bus_ack) begin
                  bus.bus_req <= 1'b0;
                  if (!bus.bus_we) begin
                     rdata <= bus.bus_rdata;
                  end
                  state <= DONE;
               end
`ifdef DMEM_CTRL_TIMEOUT_EN
               else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  // TIMEOUT BUSY cycles without ack: abandon, keep rdata.
                  bus.bus_req <= 1'b0;
                  err         <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end

            // Always return to IDLE; a request still asserted here belongs to
            // the instruction that just completed and must not re-trigger.
            DONE: state <= IDLE;

            // NOTE: the unused 2'b11 encoding recovers to IDLE.
            default: begin
               state       <= IDLE;
               bus.bus_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (works with or without
// DMEM_CTRL_TIMEOUT_EN defined).
module tb_dmem_ctrl;
   localparam int N = 16;

   logic         clk;
   logic         reset;
   logic         memread;
   logic         memwrite;
   logic [N-1:0] addr;
   logic [N-1:0] wdata;
   logic [N-1:0] rdata;
   logic         stall;
   logic         err;

   int n_cmp = 0;
   int n_err = 0;
   int pulses = 0;
   logic req_q = 1'b0;

   dmem_ctrl_if #(.N(N)) bif ();

   dmem_ctrl #(.N(N), .TIMEOUT(15)) dut (
      .clk      (clk),
      .reset    (reset),
      .memread  (memread),
      .memwrite (memwrite),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .stall    (stall),
      .err      (err),
      .bus      (bif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count bus_req rising edges, sampled mid-cycle.
   always @(negedge clk) begin
      if (bif.bus_req === 1'b1 && req_q !== 1'b1) pulses <= pulses + 1;
      req_q <= bif.bus_req;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      int cyc;
      int p0;

      reset = 1'b0; memread = 1'b0; memwrite = 1'b0;
      addr = '0; wdata = '0; bif.bus_ack = 1'b0; bif.bus_rdata = '0;

      // ---- reset state
      tick(); tick();
      check("rst_req",   32'(bif.bus_req),   32'h0);
      check("rst_we",    32'(bif.bus_we),    32'h0);
      check("rst_addr",  32'(bif.bus_addr),  32'h0);
      check("rst_wdata", 32'(bif.bus_wdata), 32'h0);
      check("rst_rdata", 32'(rdata),         32'h0);
      check("rst_err",   32'(err),           32'h0);
      check("rst_stall", 32'(stall),         32'h0);
      reset = 1'b1;
      tick();
      check("idle_noreq_stall", 32'(stall),       32'h0);
      check("idle_noreq_req",   32'(bif.bus_req), 32'h0);

      // ---- read, ack in first BUSY cycle
      addr = 16'h0040; memread = 1'b1;
      #1;
      check("rd_stall_idle", 32'(stall), 32'h1);
      tick();
      check("rd_busy_req",   32'(bif.bus_req),  32'h1);
      check("rd_busy_we",    32'(bif.bus_we),   32'h0);
      check("rd_busy_addr",  32'(bif.bus_addr), 32'h0040);
      check("rd_busy_stall", 32'(stall),        32'h1);
      bif.bus_ack = 1'b1; bif.bus_rdata = 16'hBEEF;
      tick();
      bif.bus_ack = 1'b0;
      check("rd_done_rdata", 32'(rdata),        32'hBEEF);
      check("rd_done_req",   32'(bif.bus_req),  32'h0);
      check("rd_done_stall", 32'(stall),        32'h0);
      memread = 1'b0;
      tick();
      check("rd_idle_stall", 32'(stall), 32'h0);

      // ---- write, ack on 4th BUSY cycle -> 5 stall cycles
      addr = 16'h0012; wdata = 16'h1234; memwrite = 1'b1;
      #1;
      check("wr_stall_idle", 32'(stall), 32'h1);
      tick();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("wr_busy%0d_req", i),   32'(bif.bus_req),   32'h1);
         check($sformatf("wr_busy%0d_we", i),    32'(bif.bus_we),    32'h1);
         check($sformatf("wr_busy%0d_wdata", i), 32'(bif.bus_wdata), 32'h1234);
         check($sformatf("wr_busy%0d_addr", i),  32'(bif.bus_addr),  32'h0012);
         check($sformatf("wr_busy%0d_stall", i), 32'(stall),         32'h1);
         if (i == 3) begin
            bif.bus_ack = 1'b1; bif.bus_rdata = 16'hFFFF;
         end
         tick();
      end
      bif.bus_ack = 1'b0;
      check("wr_done_req",   32'(bif.bus_req), 32'h0);
      check("wr_done_stall", 32'(stall),       32'h0);
      check("wr_done_rdata", 32'(rdata),       32'hBEEF);
      memwrite = 1'b0;
      tick();

      // ---- simultaneous read+write -> write, no re-trigger from DONE
      addr = 16'h0080; wdata = 16'h5555; memread = 1'b1; memwrite = 1'b1;
      tick();
      check("rw_busy_we", 32'(bif.bus_we), 32'h1);
      bif.bus_ack = 1'b1; bif.bus_rdata = 16'h1111;
      tick();
      bif.bus_ack = 1'b0;
      check("rw_done_rdata", 32'(rdata), 32'hBEEF);
      tick();
      check("rw_no_retrig_req",  32'(bif.bus_req), 32'h0);
      check("rw_idle_stall",     32'(stall),       32'h1);
      memread = 1'b0; memwrite = 1'b0;

      // ---- ack while IDLE is ignored
      bif.bus_ack = 1'b1; bif.bus_rdata = 16'h2222;
      tick();
      bif.bus_ack = 1'b0;
      check("idle_ack_rdata", 32'(rdata),       32'hBEEF);
      check("idle_ack_req",   32'(bif.bus_req), 32'h0);

      // ---- back-to-back loads; ack during DONE ignored
      tick();
      p0 = pulses;
      addr = 16'h0100; memread = 1'b1;
      tick();
      bif.bus_ack = 1'b1; bif.bus_rdata = 16'hA5A5;
      tick();
      check("b2b_done1_rdata", 32'(rdata), 32'hA5A5);
      bif.bus_rdata = 16'h0BAD;       // ack still high during DONE
      addr = 16'h0102;                // next instruction's load
      tick();
      bif.bus_ack = 1'b0;
      check("b2b_idle_rdata", 32'(rdata),       32'hA5A5);
      check("b2b_idle_req",   32'(bif.bus_req), 32'h0);
      check("b2b_idle_stall", 32'(stall),       32'h1);
      tick();
      check("b2b_busy2_req",  32'(bif.bus_req),  32'h1);
      check("b2b_busy2_addr", 32'(bif.bus_addr), 32'h0102);
      bif.bus_ack = 1'b1; bif.bus_rdata = 16'h5A5A;
      tick();
      bif.bus_ack = 1'b0;
      check("b2b_done2_rdata", 32'(rdata), 32'h5A5A);
      memread = 1'b0;
      tick();
      check("b2b_pulses", 32'(pulses - p0), 32'd2);

      // ---- reset in 2nd BUSY cycle, late ack ignored
      addr = 16'h0200; memread = 1'b1;
      tick();
      tick();
      check("rstb_busy2_req", 32'(bif.bus_req), 32'h1);
      reset = 1'b0;
      tick();
      check("rstb_req",   32'(bif.bus_req), 32'h0);
      check("rstb_rdata", 32'(rdata),       32'h0);
      reset = 1'b1; memread = 1'b0;
      bif.bus_ack = 1'b1; bif.bus_rdata = 16'h7777;
      tick();
      bif.bus_ack = 1'b0;
      check("rstb_late_ack_req",   32'(bif.bus_req), 32'h0);
      check("rstb_late_ack_rdata", 32'(rdata),       32'h0);
      check("rstb_late_ack_stall", 32'(stall),       32'h0);

      // ---- no ack: timeout (if built) or indefinite wait
      addr = 16'h0300; memread = 1'b1;
      tick();
      cyc = 0;
`ifdef DMEM_CTRL_TIMEOUT_EN
      while (bif.bus_req === 1'b1 && cyc < 40) begin
         cyc++;
         tick();
      end
      check("to_req_cycles", 32'(cyc),   32'd15);
      check("to_err",        32'(err),   32'h1);
      check("to_done_stall", 32'(stall), 32'h0);
      check("to_rdata",      32'(rdata), 32'h0);
      memread = 1'b0;
      tick(); tick();
      check("to_err_sticky", 32'(err), 32'h1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("to_err_cleared", 32'(err), 32'h0);
`else
      for (int i = 0; i < 100; i++) begin
         if (bif.bus_req === 1'b1) cyc++;
         tick();
      end
      check("noto_req_cycles", 32'(cyc),         32'd100);
      check("noto_req_still",  32'(bif.bus_req), 32'h1);
      check("noto_err",        32'(err),         32'h0);
      bif.bus_ack = 1'b1; bif.bus_rdata = 16'hC0DE;
      tick();
      bif.bus_ack = 1'b0;
      memread = 1'b0;
      check("noto_release_rdata", 32'(rdata), 32'hC0DE);
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
